// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN result write-back slice.
package cnn_pkg;
  localparam logic [1:0] ICB_SIZE_WORD = 2'b10;
  localparam int         WORD_BYTES    = 4;
  typedef logic [31:0] cnn_word_t;
endpackage

// File: rtl/cnn_sync_fifo.sv
// Per-channel synchronous FIFO with wrap-bit pointers and a synchronous flush.
module cnn_sync_fifo
  import cnn_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  // Equal index with differing wrap bits means the write side has lapped the read side.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/cnn_res_writeback.sv
// Multi-channel result write-back: per-channel FIFOs, round-robin ICB writer, outstanding tracking.
// Optional build macro CNN_RES_RELU_EN clamps negative results to zero as they enter the FIFOs.
module cnn_res_writeback
  import cnn_pkg::*;
#(
  parameter int CH_NUM   = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int OUTS_MAX = 4,
  parameter int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     cfg_valid,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [31:0]              cfg_addr,
  input  logic [CH_NUM-1:0]        conv_valid,
  output logic [CH_NUM-1:0]        conv_ready,
  input  logic [CH_NUM*DATA_W-1:0] conv_data,
  input  logic                     arb_block,
  output logic                     icb_cmd_valid,
  input  logic                     icb_cmd_ready,
  output logic [31:0]              icb_cmd_addr,
  output logic [31:0]              icb_cmd_wdata,
  output logic                     icb_cmd_read,
  output logic [1:0]               icb_cmd_size,
  input  logic                     icb_rsp_valid,
  output logic                     idle
);
  localparam int          OW       = $clog2(OUTS_MAX + 1);
  localparam logic [OW-1:0] OUTS_ONE = 1;

  logic [CH_NUM-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_head [CH_NUM];
  logic [DATA_W-1:0] push_data [CH_NUM];

  cnn_word_t         addr_q [CH_NUM];
  cnn_word_t         addr_d [CH_NUM];
  logic [CH_W-1:0]   rr_q, rr_d;
  logic              stage_valid_q, stage_valid_d;
  cnn_word_t         stage_addr_q, stage_addr_d;
  logic [DATA_W-1:0] stage_data_q, stage_data_d;
  logic [OW-1:0]     outs_q, outs_d;

  logic [CH_W-1:0]   sel, idx;
  logic              sel_found, hsk, load, rsp_take;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
`ifdef CNN_RES_RELU_EN
    assign push_data[i] = conv_data[i*DATA_W+DATA_W-1] ? '0 : conv_data[i*DATA_W +: DATA_W];
`else
    assign push_data[i] = conv_data[i*DATA_W +: DATA_W];
`endif
    assign fifo_push[i] = conv_valid[i] & ~fifo_full[i] & ~flush;

    cnn_sync_fifo #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push     (fifo_push[i]),
      .push_data(push_data[i]),
      .pop      (fifo_pop[i]),
      .full     (fifo_full[i]),
      .empty    (fifo_empty[i]),
      .head     (fifo_head[i])
    );
  end

  assign conv_ready    = ~fifo_full;
  assign icb_cmd_valid = stage_valid_q & (int'(outs_q) < OUTS_MAX) & ~flush;
  assign icb_cmd_addr  = stage_addr_q;
  assign icb_cmd_wdata = stage_data_q;
  assign icb_cmd_read  = 1'b0;
  assign icb_cmd_size  = ICB_SIZE_WORD;
  assign idle          = (&fifo_empty) & ~stage_valid_q & (outs_q == '0);

  assign hsk      = icb_cmd_valid & icb_cmd_ready;
  assign load     = (~stage_valid_q | hsk) & ~arb_block & ~flush & sel_found;
  assign rsp_take = icb_rsp_valid & (outs_q != '0);

  // Round-robin: first non-empty channel scanning upward from rr, wrapping.
  always_comb begin
    sel       = '0;
    idx       = '0;
    sel_found = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = CH_W'((int'(rr_q) + k) % CH_NUM);
      if (!sel_found && !fifo_empty[idx]) begin
        sel       = idx;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_addr_d  = stage_addr_q;
    stage_data_d  = stage_data_q;
    rr_d          = rr_q;
    addr_d        = addr_q;
    fifo_pop      = '0;
    outs_d        = outs_q;

    if (flush) begin
      stage_valid_d = 1'b0;
      rr_d          = '0;
    end else if (load) begin
      fifo_pop[sel] = 1'b1;
      stage_valid_d = 1'b1;
      stage_addr_d  = addr_q[sel];
      stage_data_d  = fifo_head[sel];
      addr_d[sel]   = addr_q[sel] + cnn_word_t'(WORD_BYTES);
      rr_d          = (int'(sel) == CH_NUM - 1) ? '0 : CH_W'(int'(sel) + 1);
    end else if (hsk) begin
      stage_valid_d = 1'b0;
    end

    // A base-address load overrides the post-write increment on the same channel.
    if (cfg_valid && (int'(cfg_ch) < CH_NUM)) addr_d[cfg_ch] = cfg_addr;

    if (hsk && !rsp_take)      outs_d = outs_q + OUTS_ONE;
    else if (!hsk && rsp_take) outs_d = outs_q - OUTS_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
      rr_q          <= '0;
      outs_q        <= '0;
      for (int i = 0; i < CH_NUM; i++) addr_q[i] <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
      rr_q          <= rr_d;
      outs_q        <= outs_d;
      addr_q        <= addr_d;
    end
  end
endmodule

// File: tb/tb_cnn_res_writeback.sv
// Directed self-checking bench for cnn_res_writeback with a queue-based reference model.
module tb_cnn_res_writeback;
  localparam int CH_NUM   = 4;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 8;
  localparam int OUTS_MAX = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [1:0]   cfg_ch = '0;
  logic [31:0]  cfg_addr = '0;
  logic [3:0]   conv_valid = '0;
  logic [3:0]   conv_ready;
  logic [127:0] conv_data = '0;
  logic         arb_block = 1'b0;
  logic         icb_cmd_valid;
  logic         icb_cmd_ready = 1'b0;
  logic [31:0]  icb_cmd_addr, icb_cmd_wdata;
  logic         icb_cmd_read;
  logic [1:0]   icb_cmd_size;
  logic         icb_rsp_valid = 1'b0;
  logic         idle;

  int n_checks = 0;
  int n_fail   = 0;

  bit auto_rsp   = 1'b0;
  bit manual_rsp = 1'b0;
  int pend       = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  logic [31:0] mq [CH_NUM][$];
  logic [31:0] m_addr [CH_NUM];
  int          m_rr, m_outs;
  bit          m_sv;
  logic [31:0] m_saddr, m_sdata;

  cnn_res_writeback #(
    .CH_NUM(CH_NUM), .DATA_W(DATA_W), .DEPTH(DEPTH), .OUTS_MAX(OUTS_MAX)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
    .conv_valid(conv_valid), .conv_ready(conv_ready), .conv_data(conv_data),
    .arb_block(arb_block),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_size(icb_cmd_size),
    .icb_rsp_valid(icb_rsp_valid), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] relu(input logic [31:0] d);
`ifdef CNN_RES_RELU_EN
    return d[31] ? 32'h0 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic [127:0] mk(input int ch, input logic [31:0] d);
    logic [127:0] v;
    v = '0;
    v[ch*32 +: 32] = d;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] vmask, input logic [127:0] data);
    @(negedge clk);
    conv_valid = vmask;
    conv_data  = data;
    @(negedge clk);
    conv_valid = '0;
  endtask

  task automatic cfgWrite(input logic [1:0] ch, input logic [31:0] a);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_addr  = a;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int c = 0;
    @(negedge clk);
    while (!idle && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput("idle_wait", 32'(idle), 32'd1);
  endtask

  task automatic waitLog(input int n, input int budget);
    int c = 0;
    while (log_addr.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput("log_wait", 32'(log_addr.size() >= n), 32'd1);
  endtask

  task automatic checkLog(input int i, input logic [31:0] a, input logic [31:0] d);
    if (i < log_addr.size()) begin
      checkOutput("log_addr", log_addr[i], a);
      checkOutput("log_data", log_data[i], d);
    end else begin
      checkOutput("log_missing", 32'(log_addr.size()), 32'(i + 1));
    end
  endtask

  task automatic clearLog();
    log_addr.delete();
    log_data.delete();
  endtask

  // Responder at +1 after each falling edge; model compare and update at +2.
  initial begin
    bit          hsk, ld, dec, allempty, exp_v;
    int          sel;
    bit [3:0]    pok;
    forever begin
      @(negedge clk);
      #1;
      if (auto_rsp) icb_rsp_valid = (pend > 0);
      else          icb_rsp_valid = manual_rsp;
      if (icb_rsp_valid && pend > 0) pend--;
      #1;
      if (rst) begin
        for (int i = 0; i < CH_NUM; i++) begin
          mq[i].delete();
          m_addr[i] = '0;
        end
        m_rr = 0; m_outs = 0; m_sv = 1'b0; m_saddr = '0; m_sdata = '0;
      end
      allempty = 1'b1;
      for (int i = 0; i < CH_NUM; i++) begin
        checkOutput("conv_ready", 32'(conv_ready[i]), 32'(mq[i].size() < DEPTH));
        if (mq[i].size() != 0) allempty = 1'b0;
      end
      exp_v = m_sv && (m_outs < OUTS_MAX) && !flush;
      checkOutput("cmd_valid", 32'(icb_cmd_valid), 32'(exp_v));
      if (exp_v) begin
        checkOutput("cmd_addr", icb_cmd_addr, m_saddr);
        checkOutput("cmd_wdata", icb_cmd_wdata, m_sdata);
      end
      checkOutput("idle", 32'(idle), 32'(allempty && !m_sv && m_outs == 0));
      if (icb_cmd_valid && icb_cmd_ready) begin
        log_addr.push_back(icb_cmd_addr);
        log_data.push_back(icb_cmd_wdata);
        pend++;
      end
      if (!rst) begin
        hsk = exp_v && icb_cmd_ready;
        dec = icb_rsp_valid && (m_outs > 0);
        for (int i = 0; i < CH_NUM; i++) pok[i] = conv_valid[i] && (mq[i].size() < DEPTH) && !flush;
        ld = 1'b0;
        sel = 0;
        if ((!m_sv || hsk) && !arb_block && !flush)
          for (int k = 0; k < CH_NUM; k++)
            if (!ld && mq[(m_rr + k) % CH_NUM].size() > 0) begin
              ld  = 1'b1;
              sel = (m_rr + k) % CH_NUM;
            end
        if (ld) begin
          m_sdata = mq[sel].pop_front();
          m_saddr = m_addr[sel];
          m_addr[sel] = m_addr[sel] + 32'd4;
          m_rr = (sel + 1) % CH_NUM;
          m_sv = 1'b1;
        end else if (hsk) begin
          m_sv = 1'b0;
        end
        for (int i = 0; i < CH_NUM; i++)
          if (pok[i]) mq[i].push_back(relu(conv_data[i*32 +: 32]));
        if (cfg_valid) m_addr[cfg_ch] = cfg_addr;
        m_outs = m_outs + (hsk ? 1 : 0) - (dec ? 1 : 0);
        if (flush) begin
          for (int i = 0; i < CH_NUM; i++) mq[i].delete();
          m_sv = 1'b0;
          m_rr = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", 32'(icb_cmd_valid), 32'd0);
    checkOutput("rst_ready", 32'(conv_ready), 32'hF);
    checkOutput("rst_idle", 32'(idle), 32'd1);
    checkOutput("cmd_read", 32'(icb_cmd_read), 32'd0);
    checkOutput("cmd_size", 32'(icb_cmd_size), 32'd2);

    auto_rsp = 1'b1;
    icb_cmd_ready = 1'b1;
    cfgWrite(2'd0, 32'h1000);
    cfgWrite(2'd1, 32'h2000);
    cfgWrite(2'd2, 32'h3000);
    cfgWrite(2'd3, 32'h4000);

    $display("[TB] single channel burst");
    clearLog();
    for (int k = 0; k < 3; k++) applyStimulus(4'b0001, mk(0, 32'hA0 + 32'(k)));
    waitIdle(50);
    checkOutput("t1_count", 32'(log_addr.size()), 32'd3);
    checkLog(0, 32'h1000, 32'hA0);
    checkLog(1, 32'h1004, 32'hA1);
    checkLog(2, 32'h1008, 32'hA2);

    $display("[TB] round robin order");
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    clearLog();
    applyStimulus(4'b1111, {32'h13, 32'h12, 32'h11, 32'h10});
    waitIdle(50);
    checkLog(0, 32'h100C, 32'h10);
    checkLog(1, 32'h2000, 32'h11);
    checkLog(2, 32'h3000, 32'h12);
    checkLog(3, 32'h4000, 32'h13);
    clearLog();
    applyStimulus(4'b0101, mk(0, 32'h20) | mk(2, 32'h22));
    waitIdle(50);
    checkLog(0, 32'h1010, 32'h20);
    checkLog(1, 32'h3004, 32'h22);

    $display("[TB] backpressure fill");
    clearLog();
    icb_cmd_ready = 1'b0;
    for (int k = 0; k < 9; k++) applyStimulus(4'b0001, mk(0, 32'h300 + 32'(k)));
    checkOutput("t3_full", 32'(conv_ready[0]), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("t3_nohsk", 32'(log_addr.size()), 32'd0);
    icb_cmd_ready = 1'b1;
    waitIdle(100);
    checkOutput("t3_count", 32'(log_addr.size()), 32'd9);
    for (int k = 0; k < 9; k++) checkLog(k, 32'h1014 + 32'(4 * k), 32'h300 + 32'(k));

    $display("[TB] outstanding limit");
    clearLog();
    auto_rsp = 1'b0;
    manual_rsp = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(4'b0010, mk(1, 32'h400 + 32'(k)));
    repeat (6) @(negedge clk);
    checkOutput("t4_hsk2", 32'(log_addr.size()), 32'd2);
    checkOutput("t4_blocked", 32'(icb_cmd_valid), 32'd0);
    @(negedge clk); manual_rsp = 1'b1;
    @(negedge clk); manual_rsp = 1'b0;
    checkOutput("t4_reopen", 32'(icb_cmd_valid), 32'd1);
    auto_rsp = 1'b1;
    waitIdle(50);
    for (int k = 0; k < 4; k++) checkLog(k, 32'h2004 + 32'(4 * k), 32'h400 + 32'(k));

    $display("[TB] flush with write in flight");
    clearLog();
    auto_rsp = 1'b0;
    applyStimulus(4'b1000, mk(3, 32'h500));
    waitLog(1, 20);
    icb_cmd_ready = 1'b0;
    for (int k = 1; k < 4; k++) applyStimulus(4'b1000, mk(3, 32'h500 + 32'(k)));
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checkOutput("t5_idle_busy", 32'(idle), 32'd0);
    checkOutput("t5_ready", 32'(conv_ready), 32'hF);
    @(negedge clk); manual_rsp = 1'b1;
    @(negedge clk); manual_rsp = 1'b0;
    checkOutput("t5_idle_done", 32'(idle), 32'd1);
    clearLog();
    icb_cmd_ready = 1'b1;
    auto_rsp = 1'b1;
    applyStimulus(4'b1000, mk(3, 32'h504));
    waitIdle(50);
    checkLog(0, 32'h400C, 32'h504);

    $display("[TB] arbitration block");
    clearLog();
    arb_block = 1'b1;
    applyStimulus(4'b0001, mk(0, 32'h600));
    repeat (3) @(negedge clk);
    checkOutput("arb_hold", 32'(icb_cmd_valid), 32'd0);
    arb_block = 1'b0;
    waitIdle(50);
    checkLog(0, 32'h1038, 32'h600);

    $display("[TB] relu path");
    clearLog();
    applyStimulus(4'b0010, mk(1, 32'hFFFF_FFF0));
    applyStimulus(4'b0010, mk(1, 32'h0000_0005));
    waitIdle(50);
`ifdef CNN_RES_RELU_EN
    checkLog(0, 32'h2014, 32'h0);
`else
    checkLog(0, 32'h2014, 32'hFFFF_FFF0);
`endif
    checkLog(1, 32'h2018, 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
